// File: rtl/mem_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl_pkg
// Shared definitions for the MEM-stage bus controller: bus word widths,
// READ/WRITE encoding, the default peripheral window (timer block), the
// default timeout budget, the FSM state encoding and the window decode helper.
// -----------------------------------------------------------------------------
package mem_bus_ctrl_pkg;

  localparam int WORD_ADDR_W = 32;
  localparam int WORD_DATA_W = 32;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Timer block window: low bound inclusive, high bound exclusive.
  localparam logic [WORD_ADDR_W-1:0] TIMER_ADDR_L = 32'h8000_0000;
  localparam logic [WORD_ADDR_W-1:0] TIMER_ADDR_H = 32'h8000_0100;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    BUS_ST_IDLE   = 3'd0,
    BUS_ST_REQ    = 3'd1,
    BUS_ST_ACCESS = 3'd2,
    BUS_ST_WAIT   = 3'd3,
    BUS_ST_DONE   = 3'd4
  } bus_state_e;

  function automatic logic in_window(
    input logic [WORD_ADDR_W-1:0] addr,
    input logic [WORD_ADDR_W-1:0] lo,
    input logic [WORD_ADDR_W-1:0] hi
  );
    return (addr >= lo) && (addr < hi);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_timeout_cnt.sv
// -----------------------------------------------------------------------------
// bus_timeout_cnt
// Cycle counter used to abort bus transactions that stall too long. Only
// built when BUS_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to zero
//   enable    : count one cycle
//   tc        : terminal count; high in the LIMIT-th enabled cycle after clear
// -----------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
module bus_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires while the LIMIT-th cycle is in progress, so the owner leaves after
  // exactly LIMIT cycles.
  assign tc = enable && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Routes MEM-stage loads/stores that hit the peripheral window onto the shared
// bus (request / grant / address strobe / ready handshake) and stalls the
// pipeline until the access completes.
// Optional feature: define BUS_TIMEOUT_EN to abort transactions that spend
// TIMEOUT_CYCLES cycles in REQ or WAIT (mem_err_o=1, mem_rd_data_o=0).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_req_i/rw_i/addr_i/wr_data_i   pipeline access request
//   mem_rd_data_o               load data, held until the next read completion
//   mem_done_o                  one-cycle completion pulse
//   mem_stall_o                 pipeline hold (combinational)
//   mem_err_o                   timeout flag, valid with mem_done_o
//   bus_mem_req/grnt            arbiter handshake
//   bus_mem_as/rw/addr/wr_data  bus master outputs
//   bus_mem_rdy/rd_data         slave response
// -----------------------------------------------------------------------------
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int                     TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [WORD_ADDR_W-1:0] PERIPH_ADDR_L  = TIMER_ADDR_L,
  parameter logic [WORD_ADDR_W-1:0] PERIPH_ADDR_H  = TIMER_ADDR_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_i,
  input  logic                   mem_rw_i,
  input  logic [WORD_ADDR_W-1:0] mem_addr_i,
  input  logic [WORD_DATA_W-1:0] mem_wr_data_i,
  output logic [WORD_DATA_W-1:0] mem_rd_data_o,
  output logic                   mem_done_o,
  output logic                   mem_stall_o,
  output logic                   mem_err_o,
  output logic                   bus_mem_req,
  input  logic                   bus_mem_grnt,
  output logic                   bus_mem_as,
  output logic                   bus_mem_rw,
  output logic [WORD_ADDR_W-1:0] bus_mem_addr,
  output logic [WORD_DATA_W-1:0] bus_mem_wr_data,
  input  logic                   bus_mem_rdy,
  input  logic [WORD_DATA_W-1:0] bus_mem_rd_data
);

  bus_state_e state, state_nxt;

  logic accept;    // in-window request taken in IDLE
  logic complete;  // slave ready during ACCESS/WAIT
  logic abort;     // timeout while still waiting on grant or ready
  logic timeout;

  assign accept   = (state == BUS_ST_IDLE) && mem_req_i &&
                    in_window(mem_addr_i, PERIPH_ADDR_L, PERIPH_ADDR_H);
  assign complete = ((state == BUS_ST_ACCESS) || (state == BUS_ST_WAIT)) && bus_mem_rdy;
  // A grant or ready arriving in the terminal cycle wins over the timeout.
  assign abort    = ((state == BUS_ST_REQ)  && !bus_mem_grnt && timeout) ||
                    ((state == BUS_ST_WAIT) && !bus_mem_rdy  && timeout);

`ifdef BUS_TIMEOUT_EN
  logic waiting;
  assign waiting = (state == BUS_ST_REQ) || (state == BUS_ST_WAIT);

  // Held clear outside REQ/WAIT, so it starts from zero on every entry.
  bus_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waiting),
    .enable (waiting),
    .tc     (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BUS_ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BUS_ST_IDLE:   if (accept) state_nxt = BUS_ST_REQ;
      BUS_ST_REQ:    if (bus_mem_grnt) state_nxt = BUS_ST_ACCESS;
                     else if (abort)   state_nxt = BUS_ST_DONE;
      BUS_ST_ACCESS: state_nxt = bus_mem_rdy ? BUS_ST_DONE : BUS_ST_WAIT;
      BUS_ST_WAIT:   if (bus_mem_rdy || abort) state_nxt = BUS_ST_DONE;
      BUS_ST_DONE:   state_nxt = BUS_ST_IDLE;
      default:       state_nxt = BUS_ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    bus_mem_req = 1'b0;
    bus_mem_as  = 1'b0;
    mem_done_o  = 1'b0;
    mem_stall_o = accept;
    unique case (state)
      BUS_ST_REQ,
      BUS_ST_WAIT: begin
        bus_mem_req = 1'b1;
        mem_stall_o = 1'b1;
      end
      BUS_ST_ACCESS: begin
        bus_mem_req = 1'b1;
        bus_mem_as  = 1'b1;
        mem_stall_o = 1'b1;
      end
      BUS_ST_DONE: mem_done_o = 1'b1;
      default: ;
    endcase
  end

  // Latched transaction, load data and error flag. The bus address/data lines
  // only change on accept, so they hold their value outside ACCESS as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_mem_addr    <= '0;
      bus_mem_wr_data <= '0;
      bus_mem_rw      <= READ;
      mem_rd_data_o   <= '0;
      mem_err_o       <= 1'b0;
    end else begin
      if (accept) begin
        bus_mem_addr    <= mem_addr_i;
        bus_mem_wr_data <= mem_wr_data_i;
        bus_mem_rw      <= mem_rw_i;
        mem_err_o       <= 1'b0;
      end
      if (complete && (bus_mem_rw == READ)) begin
        mem_rd_data_o <= bus_mem_rd_data;
      end
      if (abort) begin
        mem_rd_data_o <= '0;
        mem_err_o     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Directed bench for mem_bus_ctrl with default parameters (window
// 32'h8000_0000..32'h8000_0100, timeout 16). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. Cycle numbers in the
// comments count from the cycle in which the request is presented (cycle 0).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i;
  logic        mem_rw_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wr_data_i;
  logic [31:0] mem_rd_data_o;
  logic        mem_done_o;
  logic        mem_stall_o;
  logic        mem_err_o;
  logic        bus_mem_req;
  logic        bus_mem_grnt;
  logic        bus_mem_as;
  logic        bus_mem_rw;
  logic [31:0] bus_mem_addr;
  logic [31:0] bus_mem_wr_data;
  logic        bus_mem_rdy;
  logic [31:0] bus_mem_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_i       (mem_req_i),
    .mem_rw_i        (mem_rw_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wr_data_i   (mem_wr_data_i),
    .mem_rd_data_o   (mem_rd_data_o),
    .mem_done_o      (mem_done_o),
    .mem_stall_o     (mem_stall_o),
    .mem_err_o       (mem_err_o),
    .bus_mem_req     (bus_mem_req),
    .bus_mem_grnt    (bus_mem_grnt),
    .bus_mem_as      (bus_mem_as),
    .bus_mem_rw      (bus_mem_rw),
    .bus_mem_addr    (bus_mem_addr),
    .bus_mem_wr_data (bus_mem_wr_data),
    .bus_mem_rdy     (bus_mem_rdy),
    .bus_mem_rd_data (bus_mem_rd_data)
  );

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_req_i = 1'b0; mem_rw_i = 1'b0; mem_addr_i = '0;
    mem_wr_data_i = '0; bus_mem_grnt = 1'b0; bus_mem_rdy = 1'b0; bus_mem_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus_mem_req); end
    checks++; if (bus_mem_as !== 1'b0) begin errors++; $display("FAIL rst_as got %b exp 0", bus_mem_as); end
    checks++; if (bus_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus_mem_addr); end
    checks++; if (bus_mem_wr_data !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus_mem_wr_data); end
    checks++; if (bus_mem_rw !== 1'b0) begin errors++; $display("FAIL rst_rw got %b exp 0", bus_mem_rw); end
    checks++; if (mem_rd_data_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", mem_rd_data_o); end
    checks++; if ({mem_done_o, mem_err_o, mem_stall_o} !== 3'b000) begin errors++; $display("FAIL rst_done_err_stall got %b exp 000", {mem_done_o, mem_err_o, mem_stall_o}); end
    step;
    rst = 1'b0;
  endtask

  // Write, grant and ready already high: minimum latency path.
  task automatic test_write;
    step; // cycle 0
    mem_req_i = 1'b1; mem_rw_i = 1'b1; mem_addr_i = 32'h8000_0000;
    mem_wr_data_i = 32'hA5A5_0001; bus_mem_grnt = 1'b1; bus_mem_rdy = 1'b1;
    @(negedge clk);
    checks++; if (mem_stall_o !== 1'b1) begin errors++; $display("FAIL wr_c0_stall got %b exp 1", mem_stall_o); end
    checks++; if (bus_mem_req !== 1'b0) begin errors++; $display("FAIL wr_c0_req got %b exp 0", bus_mem_req); end
    step; // cycle 1: REQ; pipeline inputs change but must be ignored
    mem_req_i = 1'b0; mem_rw_i = 1'b0; mem_addr_i = 32'h8000_0040; mem_wr_data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({bus_mem_req, bus_mem_as, mem_stall_o} !== 3'b101) begin errors++; $display("FAIL wr_c1_req_as_stall got %b exp 101", {bus_mem_req, bus_mem_as, mem_stall_o}); end
    checks++; if (bus_mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL wr_c1_addr got %h exp 80000000", bus_mem_addr); end
    step; // cycle 2: ACCESS
    @(negedge clk);
    checks++; if ({bus_mem_req, bus_mem_as, mem_stall_o} !== 3'b111) begin errors++; $display("FAIL wr_c2_req_as_stall got %b exp 111", {bus_mem_req, bus_mem_as, mem_stall_o}); end
    checks++; if (bus_mem_rw !== 1'b1) begin errors++; $display("FAIL wr_c2_rw got %b exp 1", bus_mem_rw); end
    checks++; if (bus_mem_wr_data !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_c2_wdata got %h exp a5a50001", bus_mem_wr_data); end
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL wr_c2_done got %b exp 0", mem_done_o); end
    step; // cycle 3: DONE
    @(negedge clk);
    checks++; if ({mem_done_o, mem_stall_o, bus_mem_req, bus_mem_as, mem_err_o} !== 5'b10000) begin errors++; $display("FAIL wr_c3_done_stall_req_as_err got %b exp 10000", {mem_done_o, mem_stall_o, bus_mem_req, bus_mem_as, mem_err_o}); end
    checks++; if (mem_rd_data_o !== 32'h0) begin errors++; $display("FAIL wr_c3_rdata got %h exp 0", mem_rd_data_o); end
    step; // cycle 4: IDLE, bus lines hold latched values
    @(negedge clk);
    checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL wr_c4_done got %b exp 0", mem_done_o); end
    checks++; if (bus_mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL wr_c4_addr_hold got %h exp 80000000", bus_mem_addr); end
  endtask

  // Read: grant in cycle 3 (ACCESS in 4), ready in cycle 6 (DONE in 7).
  task automatic test_read_delayed;
    int as_count = 0;
    step; // cycle 0
    mem_req_i = 1'b1; mem_rw_i = 1'b0; mem_addr_i = 32'h8000_0004;
    bus_mem_grnt = 1'b0; bus_mem_rdy = 1'b0; bus_mem_rd_data = 32'hDEAD_BEEF;
    for (int c = 1; c <= 6; c++) begin
      step;
      mem_req_i = 1'b0;
      bus_mem_grnt = (c >= 3);
      bus_mem_rdy  = (c >= 6);
      bus_mem_rd_data = (c >= 6) ? 32'h1234_5678 : 32'hDEAD_BEEF;
      @(negedge clk);
      if (bus_mem_as === 1'b1) as_count++;
      checks++; if ({bus_mem_req, mem_stall_o, mem_done_o} !== 3'b110) begin errors++; $display("FAIL rd_c%0d_req_stall_done got %b exp 110", c, {bus_mem_req, mem_stall_o, mem_done_o}); end
      checks++; if (bus_mem_as !== (c == 4)) begin errors++; $display("FAIL rd_c%0d_as got %b exp %b", c, bus_mem_as, (c == 4)); end
    end
    step; // cycle 7: DONE
    bus_mem_rdy = 1'b0; bus_mem_rd_data = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++; if (mem_done_o !== 1'b1) begin errors++; $display("FAIL rd_c7_done got %b exp 1", mem_done_o); end
    checks++; if (mem_rd_data_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_c7_rdata got %h exp 12345678", mem_rd_data_o); end
    checks++; if (as_count != 1) begin errors++; $display("FAIL rd_as_pulses got %0d exp 1", as_count); end
    step; // cycle 8: IDLE, data holds
    @(negedge clk);
    checks++; if (mem_rd_data_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_c8_rdata_hold got %h exp 12345678", mem_rd_data_o); end
  endtask

  // Request held during DONE is ignored there and accepted the next cycle.
  task automatic test_back_to_back;
    bus_mem_grnt = 1'b1; bus_mem_rdy = 1'b1;
    step; // cycle 0
    mem_req_i = 1'b1; mem_rw_i = 1'b1; mem_addr_i = 32'h8000_0008; mem_wr_data_i = 32'h1111_1111;
    step; mem_req_i = 1'b0; // cycle 1
    step;                   // cycle 2
    step;                   // cycle 3: DONE of first write
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_000C; mem_wr_data_i = 32'h2222_2222;
    @(negedge clk);
    checks++; if ({mem_done_o, mem_stall_o} !== 2'b10) begin errors++; $display("FAIL b2b_c3_done_stall got %b exp 10", {mem_done_o, mem_stall_o}); end
    step; // cycle 4: IDLE accepts second write
    @(negedge clk);
    checks++; if ({mem_done_o, mem_stall_o, bus_mem_req} !== 3'b010) begin errors++; $display("FAIL b2b_c4_done_stall_req got %b exp 010", {mem_done_o, mem_stall_o, bus_mem_req}); end
    step; mem_req_i = 1'b0; // cycle 5: REQ
    @(negedge clk);
    checks++; if ({bus_mem_req, bus_mem_as} !== 2'b10) begin errors++; $display("FAIL b2b_c5_req_as got %b exp 10", {bus_mem_req, bus_mem_as}); end
    step; // cycle 6: ACCESS
    @(negedge clk);
    checks++; if (bus_mem_as !== 1'b1) begin errors++; $display("FAIL b2b_c6_as got %b exp 1", bus_mem_as); end
    checks++; if ({bus_mem_addr, bus_mem_wr_data} !== {32'h8000_000C, 32'h2222_2222}) begin errors++; $display("FAIL b2b_c6_addr_wdata got %h exp 8000000c22222222", {bus_mem_addr, bus_mem_wr_data}); end
    step; // cycle 7: DONE, write leaves load data alone
    @(negedge clk);
    checks++; if (mem_done_o !== 1'b1) begin errors++; $display("FAIL b2b_c7_done got %b exp 1", mem_done_o); end
    checks++; if (mem_rd_data_o !== 32'h1234_5678) begin errors++; $display("FAIL b2b_c7_rdata got %h exp 12345678", mem_rd_data_o); end
  endtask

  task automatic test_out_of_window;
    step;
    mem_req_i = 1'b1; mem_rw_i = 1'b0; mem_addr_i = 32'h0000_0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({bus_mem_req, mem_stall_o, mem_done_o, bus_mem_as} !== 4'b0000) begin errors++; $display("FAIL oow_c%0d_req_stall_done_as got %b exp 0000", c, {bus_mem_req, mem_stall_o, mem_done_o, bus_mem_as}); end
      step;
    end
    mem_req_i = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    step; // cycle 0
    mem_req_i = 1'b1; mem_rw_i = 1'b0; mem_addr_i = 32'h8000_0010;
    bus_mem_grnt = 1'b1; bus_mem_rdy = 1'b0;
    step; mem_req_i = 1'b0; // cycle 1 REQ
    step;                   // cycle 2 ACCESS
    step;                   // cycle 3 WAIT
    @(negedge clk);
    checks++; if ({bus_mem_req, bus_mem_as, mem_stall_o} !== 3'b101) begin errors++; $display("FAIL rw_c3_req_as_stall got %b exp 101", {bus_mem_req, bus_mem_as, mem_stall_o}); end
    rst = 1'b1;
    step; // cycle 4: reset taken
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus_mem_req, bus_mem_as, bus_mem_rw, mem_done_o, mem_stall_o} !== 5'b00000) begin errors++; $display("FAIL rw_c4_req_as_rw_done_stall got %b exp 00000", {bus_mem_req, bus_mem_as, bus_mem_rw, mem_done_o, mem_stall_o}); end
    checks++; if ({bus_mem_addr, bus_mem_wr_data, mem_rd_data_o} !== 96'h0) begin errors++; $display("FAIL rw_c4_addr_wdata_rdata got %h exp 0", {bus_mem_addr, bus_mem_wr_data, mem_rd_data_o}); end
    // Fresh read completes normally.
    bus_mem_rdy = 1'b1; bus_mem_rd_data = 32'hCAFE_F00D;
    step;
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_0014;
    step; mem_req_i = 1'b0;
    step;
    step;
    @(negedge clk);
    checks++; if (mem_done_o !== 1'b1) begin errors++; $display("FAIL rw_after_done got %b exp 1", mem_done_o); end
    checks++; if (mem_rd_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rw_after_rdata got %h exp cafef00d", mem_rd_data_o); end
  endtask

  // Grant never arrives.
  task automatic test_timeout;
    step; // cycle 0
    mem_req_i = 1'b1; mem_rw_i = 1'b0; mem_addr_i = 32'h8000_0018;
    bus_mem_grnt = 1'b0; bus_mem_rdy = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step;
      mem_req_i = 1'b0;
      @(negedge clk);
      checks++; if ({mem_stall_o, mem_done_o} !== 2'b10) begin errors++; $display("FAIL to_c%0d_stall_done got %b exp 10", c, {mem_stall_o, mem_done_o}); end
    end
`ifdef BUS_TIMEOUT_EN
    step; // cycle 17: DONE with error
    @(negedge clk);
    checks++; if ({mem_done_o, mem_err_o, mem_stall_o} !== 3'b110) begin errors++; $display("FAIL to_c17_done_err_stall got %b exp 110", {mem_done_o, mem_err_o, mem_stall_o}); end
    checks++; if (mem_rd_data_o !== 32'h0) begin errors++; $display("FAIL to_c17_rdata got %h exp 0", mem_rd_data_o); end
    step; // cycle 18: IDLE, error persists
    @(negedge clk);
    checks++; if ({mem_done_o, mem_err_o} !== 2'b01) begin errors++; $display("FAIL to_c18_done_err got %b exp 01", {mem_done_o, mem_err_o}); end
    // Next accepted request clears the flag.
    bus_mem_grnt = 1'b1; bus_mem_rdy = 1'b1;
    step;
    mem_req_i = 1'b1; mem_rw_i = 1'b1; mem_addr_i = 32'h8000_001C;
    step; mem_req_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_err_o !== 1'b0) begin errors++; $display("FAIL to_clear_err got %b exp 0", mem_err_o); end
    step;
    step;
    @(negedge clk);
    checks++; if ({mem_done_o, mem_err_o} !== 2'b10) begin errors++; $display("FAIL to_next_done_err got %b exp 10", {mem_done_o, mem_err_o}); end
`else
    for (int c = 17; c <= 40; c++) begin
      step;
      @(negedge clk);
      checks++; if ({mem_stall_o, mem_done_o, mem_err_o} !== 3'b100) begin errors++; $display("FAIL nto_c%0d_stall_done_err got %b exp 100", c, {mem_stall_o, mem_done_o, mem_err_o}); end
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({mem_stall_o, bus_mem_req} !== 2'b00) begin errors++; $display("FAIL nto_rst_stall_req got %b exp 00", {mem_stall_o, bus_mem_req}); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_delayed();
    test_back_to_back();
    test_out_of_window();
    test_reset_in_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
